// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add multiplier sequencer driving one external WIDTH-bit adder.
// Optional feature macro: MUL_SEQ_ZERO_SKIP_EN (zero operand bypasses CALC).
module mul_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [WIDTH-1:0]   adder_a,
  output logic [WIDTH-1:0]   adder_b,
  output logic               adder_cin,
  input  logic [WIDTH-1:0]   adder_sum,
  input  logic               adder_cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_add_en;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_zero;
  logic [WIDTH:0]       w_hi_next;
  logic [2*WIDTH-1:0]   w_acc_next;

`ifdef MUL_SEQ_ZERO_SKIP_EN
  assign w_zero = (op_a == '0) || (op_b == '0);
`else
  assign w_zero = 1'b0;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_CALC) || (r_state == S_DONE);
  assign product   = r_product;

  // The adder sees operands only on iterations that actually add.
  assign w_add_en  = (r_state == S_CALC) && r_acc_lo[0];
  assign adder_a   = w_add_en ? r_acc_hi : '0;
  assign adder_b   = w_add_en ? r_mcand  : '0;
  assign adder_cin = 1'b0;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_count == CNT_W'(WIDTH - 1));
  assign w_hi_next  = w_add_en ? {adder_cout, adder_sum} : {1'b0, r_acc_hi};
  assign w_acc_next = {w_hi_next, r_acc_lo[WIDTH-1:1]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= op_a;
            r_acc_hi <= '0;
            r_acc_lo <= w_zero ? '0 : op_b;
            r_count  <= '0;
            if (w_zero) begin
              r_product <= '0;
            end
          end
        end
        S_CALC: begin
          {r_acc_hi, r_acc_lo} <= w_acc_next;
          r_count              <= r_count + CNT_W'(1);
          // Product register only changes when a result is published.
          if (w_last) begin
            r_product <= w_acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
